instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder in the 8-bit CPU. It owns the program counter, issues requests to instruction memory, and latches the returned byte into an instruction register. It presents that instruction to the decoder through a valid/ready handshake. It also handles taken-branch redirects and the HLT opcode.

Parameters:
ADDR_W, 8, width of PC and instruction-memory address
RESET_PC, 8'h00, PC value loaded on reset
HLT_OPCODE, 4'hF, value of instruction[7:4] that halts fetch once accepted

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  level request to instruction memory
imem_addr  output  ADDR_W  fetch address; stable while imem_req=1
imem_rdata  input  8  instruction byte from memory
imem_valid  input  1  rdata valid; may assert in the same cycle as imem_req, or any later cycle
instr_out  output  8  instruction register, feeds the decoder's instruction input
instr_valid  output  1  instr_out holds a live instruction
instr_ready  input  1  downstream accepts instr_out this cycle
pc_out  output  ADDR_W  address of the instruction in instr_out
branch_taken  input  1  one-cycle redirect pulse from execute
branch_target  input  ADDR_W  redirect address, sampled when branch_taken=1
halted  output  1  fetch stopped on HLT

Behaviour:
- Reset (async assert, sync deassert handled upstream): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_out=8'h00, instr_valid=0, pc_out=RESET_PC, halted=0. Reset asserted mid-operation aborts everything immediately. Any outstanding memory response is ignored.
- States: IDLE, REQ, DRAIN, HOLD, HALTED. All registered; outputs are decoded from state and registers.
- IDLE: lasts one cycle after reset release, then moves to REQ.
- REQ: imem_req=1, imem_addr=pc.
  - On imem_valid=1: instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, go to HOLD.
- HOLD: imem_req=0, instr_valid=1, instr_out held stable.
  - On instr_ready=1: pc<=pc+1 (wraps 8'hFF->8'h00), instr_valid<=0.
  - Then go to HALTED if instr_out[7:4]==HLT_OPCODE, else go to REQ.
- HALTED: imem_req=0, instr_valid=0, halted=1. The only exit is reset. branch_taken is ignored here.
- Branch in HOLD (priority over instr_ready): pc<=branch_target, instr_valid<=0 (instruction squashed, never accepted), go to REQ. HLT is not honoured if squashed.
- Branch in REQ with imem_valid=1 in the same cycle: discard rdata, pc<=branch_target, stay in REQ (new address next cycle).
- Branch in REQ with imem_valid=0: pc<=branch_target, go to DRAIN. imem_addr keeps the old address and imem_req stays 1 until the response arrives.
- DRAIN: imem_req=1 with the old address. On imem_valid, discard the data and go to REQ with the new pc. A second branch in DRAIN overwrites pc; the last one wins.
- Branch in IDLE: pc<=branch_target, go to REQ.
- Latency with zero-wait memory: instr_valid rises 2 cycles after reset release.
- Throughput: minimum 2 cycles per instruction (REQ plus HOLD).
- Each memory wait cycle adds one cycle.
- instr_out, pc_out, and instr_valid never change while instr_valid=1 and instr_ready=0, except on branch.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: NOP=4'h0, ADD..XOR=4'h1..4'h7, HLT=4'hF
  - fetch state enum: IDLE, REQ, DRAIN, HOLD, HALTED
  - ADDR_W default
- One sub-module: pc_reg, the PC register with load/increment/wrap. Everything else lives in instruction_fetch.

Test Plan:
1. Reset release, memory ROM[0]=8'h12 zero-wait, instr_ready=1 -> imem_addr=8'h00 in cycle 1. instr_valid=1 with instr_out=8'h12, pc_out=8'h00 in cycle 2. Next request at addr 8'h01.
2. Backpressure: instr_ready=0 for 5 cycles while ROM[3]=8'h5A is presented -> instr_out stays 8'h5A, instr_valid stays 1, imem_req=0. Next fetch is addr 8'h04 only after ready rises.
3. Wrap: pc=8'hFF accepted -> next imem_addr=8'h00.
4. Branch during a 3-cycle memory wait, target 8'h40 -> old addr held until valid, data discarded, never seen with instr_valid. Next request is 8'h40.
5. Branch in HOLD while instr_ready=1, target 8'h10 -> squashed, no PC increment, next request 8'h10.
6. ROM[2]=8'hF0 accepted -> halted=1, imem_req=0 forever. rst_n low then high -> fetch restarts at 8'h00, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode map, fetch FSM states and default widths.
package cpu_pkg;

    localparam int DEFAULT_ADDR_W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment; increment wraps at the top address.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC selection.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives instruction memory, latches the returned byte and hands it to the
// decoder over valid/ready, with branch redirect and HLT stop.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter logic [3:0]        HLT_OPCODE = OP_HLT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    input  logic              imem_valid,
    output logic [7:0]        instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic              pc_load_s, pc_inc_s;
    logic [ADDR_W-1:0] pc_s, pc_next_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              req_q, valid_q, halted_q;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pc_load_s),
        .load_val_i (branch_target),
        .inc_i      (pc_inc_s),
        .pc_o       (pc_s),
        .pc_next_o  (pc_next_s)
    );

    // Next-state, PC control and instruction capture.
    always_comb begin
        state_d   = state_q;
        pc_load_s = 1'b0;
        pc_inc_s  = 1'b0;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        case (state_q)
            ST_IDLE: begin
                pc_load_s = branch_taken;
                state_d   = ST_REQ;
            end
            ST_REQ: begin
                if (branch_taken) begin
                    pc_load_s = 1'b1;
                    state_d   = imem_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_valid) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_s;
                    state_d  = ST_HOLD;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                pc_load_s = branch_taken;
                state_d   = imem_valid ? ST_REQ : ST_DRAIN;
            end
            ST_HOLD: begin
                // A redirect squashes the held instruction, including a pending HLT.
                if (branch_taken) begin
                    pc_load_s = 1'b1;
                    state_d   = ST_REQ;
                end else if (instr_ready) begin
                    pc_inc_s = 1'b1;
                    state_d  = (instr_q[7:4] == HLT_OPCODE) ? ST_HALTED : ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The fetch address only moves when a fresh request starts; DRAIN keeps the old one.
    always_comb begin
        if (state_d == ST_REQ) begin
            addr_d = pc_next_s;
        end else begin
            addr_d = addr_q;
        end
    end

    // State and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= RESET_PC;
            instr_q  <= 8'h00;
            pc_out_q <= RESET_PC;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            req_q    <= (state_d == ST_REQ) || (state_d == ST_DRAIN);
            valid_q  <= (state_d == ST_HOLD);
            halted_q <= (state_d == ST_HALTED);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for streaming/backpressure/branch-in-HOLD
// plus hand sequences for wrap, memory-wait redirects, HLT and reset.
module tb_instruction_fetch;

    logic       clk;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_valid;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc_out;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halted;

    instruction_fetch #(
        .ADDR_W     (8),
        .RESET_PC   (8'h00),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_out        (pc_out),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted)
    );

    typedef struct {
        logic       rdy;
        logic       br;
        logic [7:0] tgt;
        logic       req;
        logic [7:0] addr;
        logic       vld;
        logic [7:0] ins;
        logic [7:0] pco;
        logic       hlt;
    } vec_t;

    logic [7:0] rom [0:255];
    int         wait_cfg;
    int         wait_left;
    int         n_vec;
    int         n_miss;
    vec_t       tab [0:19];
    vec_t       rst_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rdy, input logic br, input logic [7:0] tgt,
                                input logic req, input logic [7:0] addr, input logic vld,
                                input logic [7:0] ins, input logic [7:0] pco, input logic hlt);
        vec_t v;
        v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.pco = pco; v.hlt = hlt;
        return v;
    endfunction

    // Memory model answers after wait_cfg wait cycles per request, then clocks once.
    task automatic tick();
        imem_valid = imem_req && (wait_left == 0);
        imem_rdata = rom[imem_addr];
        @(posedge clk);
        if (imem_req) begin
            if (wait_left == 0) wait_left = wait_cfg;
            else                wait_left = wait_left - 1;
        end
        #1;
    endtask

    task automatic chk(input string nm, input vec_t e, input bit full);
        bit bad;
        bad = (imem_req !== e.req) || (instr_valid !== e.vld) || (halted !== e.hlt);
        if (full || e.req) bad = bad || (imem_addr !== e.addr);
        if (full || e.vld) bad = bad || (instr_out !== e.ins) || (pc_out !== e.pco);
        n_vec = n_vec + 1;
        if (bad) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got req=%b addr=%h vld=%b ins=%h pc=%h hlt=%b, want req=%b addr=%h vld=%b ins=%h pc=%h hlt=%b",
                     nm, imem_req, imem_addr, instr_valid, instr_out, pc_out, halted,
                     e.req, e.addr, e.vld, e.ins, e.pco, e.hlt);
        end
    endtask

    task automatic step(input string nm, input vec_t e);
        instr_ready   = e.rdy;
        branch_taken  = e.br;
        branch_target = e.tgt;
        tick();
        branch_taken  = 1'b0;
        chk(nm, e, 1'b0);
    endtask

    task automatic do_reset(input int wc);
        rst_n        = 1'b0;
        wait_cfg     = wc;
        wait_left    = wc;
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        #2;
        chk("reset_async", rst_vec, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_state", rst_vec, 1'b1);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        imem_valid    = 1'b0;
        imem_rdata    = 8'h00;
        instr_ready   = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[8'h00] = 8'h12; rom[8'h01] = 8'h34; rom[8'h02] = 8'h56; rom[8'h03] = 8'h5A;
        rom[8'h04] = 8'h21; rom[8'h05] = 8'h44; rom[8'h10] = 8'hF5; rom[8'h20] = 8'h66;
        rom[8'h40] = 8'h99; rom[8'hFF] = 8'h77;
        rst_vec = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

        //        rdy   br    tgt    req   addr   vld   ins    pco    hlt
        tab[0]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        tab[1]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h12, 8'h00, 1'b0);
        tab[2]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0);
        tab[3]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h34, 8'h01, 1'b0);
        tab[4]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b0);
        tab[5]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h56, 8'h02, 1'b0);
        tab[6]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0);
        tab[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h03, 1'b0);
        for (int i = 8; i <= 12; i++)
            tab[i] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h03, 1'b0);
        tab[13] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0);
        tab[14] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h21, 8'h04, 1'b0);
        tab[15] = mk(1'b1, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0);
        tab[16] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hF5, 8'h10, 1'b0);
        tab[17] = mk(1'b1, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0);
        tab[18] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h44, 8'h05, 1'b0);
        tab[19] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 8'h00, 8'h00, 1'b0);

        // Streaming, backpressure on 5A, branch in HOLD (incl. squashed HLT-class opcode F5).
        do_reset(0);
        for (int i = 0; i < 20; i++) step($sformatf("tab%0d", i), tab[i]);

        // Branch in IDLE to FF, then PC wraps to 00.
        do_reset(0);
        step("idle_br", mk(1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0));
        step("ff_hold", mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h77, 8'hFF, 1'b0));
        step("wrap",    mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));

        // Branch in REQ coinciding with the response: data dropped, new address next cycle.
        do_reset(0);
        step("req0",    mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        step("req_brv", mk(1'b1, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0, 8'h00, 8'h00, 1'b0));
        step("req_new", mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h66, 8'h20, 1'b0));

        // 3-wait memory: branch to 30 during wait, second branch to 40 in DRAIN wins.
        do_reset(3);
        step("w_req",   mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        step("w_br1",   mk(1'b1, 1'b1, 8'h30, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        step("w_br2",   mk(1'b1, 1'b1, 8'h40, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        step("w_drain", mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        step("w_resp",  mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0));
        for (int i = 0; i < 3; i++)
            step($sformatf("w_wait%0d", i), mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0));
        step("w_hold",  mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h99, 8'h40, 1'b0));

        // HLT at address 2: fetch stops for good, branches ignored, reset restarts.
        rom[8'h02] = 8'hF0;
        do_reset(0);
        step("h_req0",  mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        step("h_hold0", mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h12, 8'h00, 1'b0));
        step("h_req1",  mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0));
        step("h_hold1", mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h34, 8'h01, 1'b0));
        step("h_req2",  mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b0));
        step("h_hold2", mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hF0, 8'h02, 1'b0));
        step("h_halt",  mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1));
        for (int i = 0; i < 3; i++)
            step($sformatf("h_stay%0d", i), mk(1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1));
        do_reset(0);
        step("r_req0",  mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        step("r_hold0", mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h12, 8'h00, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
